// File: rtl/alu_share_arbiter_if.sv
// rtl/alu_share_arbiter_if.sv - request/response bundle between issue logic and the shared-ALU arbiter
interface alu_share_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 4
);
    // Request side: two requesters packed side by side, requester i in slice i
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*XLEN-1:0]  req_a;
    logic [2*XLEN-1:0]  req_b;
    logic [7:0]         req_sel;
    logic [2*TAG_W-1:0] req_tag;

    // Response side: one buffered entry per requester
    logic [1:0]         resp_valid;
    logic [1:0]         resp_ready;
    logic [2*XLEN-1:0]  resp_result;
    logic [2*TAG_W-1:0] resp_tag;
    logic [1:0]         resp_err;

    // Issue logic / consumer side
    modport master (
        output req_valid, req_a, req_b, req_sel, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_tag, resp_err
    );

    // Arbiter side
    modport slave (
        input  req_valid, req_a, req_b, req_sel, req_tag, resp_ready,
        output req_ready, resp_valid, resp_result, resp_tag, resp_err
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one combinational ALU between two requesters (optional ARB_STATS_EN adds busy/conflict counters)
module alu_share_arbiter #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 4,
    parameter int NUM_OPS = 10
`ifdef ARB_STATS_EN
    ,
    parameter int CNT_W   = 16
`endif
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    alu_share_arbiter_if.slave   bus,
    output logic [XLEN-1:0]      o_alu_in_a,
    output logic [XLEN-1:0]      o_alu_in_b,
    output logic [3:0]           o_alu_select,
    input  logic [XLEN-1:0]      i_alu_result
`ifdef ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     o_stat_busy,
    output logic [CNT_W-1:0]     o_stat_conflict
`endif
);

    // Select codes at or above this bound are rejected with a zero result
    localparam logic [4:0] LP_NUM_OPS = 5'(NUM_OPS);

    logic [1:0]                  w_elig;
    logic [1:0]                  w_grant;
    logic                        w_any_grant;
    logic                        w_sel_ok;
    logic [TAG_W-1:0]            w_mux_tag;

    logic [1:0]                  r_resp_valid;
    logic [1:0][XLEN-1:0]        r_resp_result;
    logic [1:0][TAG_W-1:0]       r_resp_tag;
    logic [1:0]                  r_resp_err;
    logic                        r_rr_last;

    // A requester may issue when its buffer is empty or is being drained this cycle
    always_comb begin
        w_elig = 2'b00;
        for (int i = 0; i < 2; i++) begin
            w_elig[i] = bus.req_valid[i] && (!r_resp_valid[i] || bus.resp_ready[i]);
        end
    end

    // Round-robin pick: on conflict the requester that did not win last time goes
    always_comb begin
        w_grant = w_elig;
        if (w_elig == 2'b11) begin
            w_grant = r_rr_last ? 2'b01 : 2'b10;
        end
    end

    assign w_any_grant   = |w_grant;
    assign bus.req_ready = w_grant;

    // Steer the granted operands to the ALU; idle drives ADD 0+0 so no stale select lingers
    always_comb begin
        o_alu_in_a   = '0;
        o_alu_in_b   = '0;
        o_alu_select = 4'd0;
        w_mux_tag    = '0;
        if (w_grant[1]) begin
            o_alu_in_a   = bus.req_a[2*XLEN-1:XLEN];
            o_alu_in_b   = bus.req_b[2*XLEN-1:XLEN];
            o_alu_select = bus.req_sel[7:4];
            w_mux_tag    = bus.req_tag[2*TAG_W-1:TAG_W];
        end else if (w_grant[0]) begin
            o_alu_in_a   = bus.req_a[XLEN-1:0];
            o_alu_in_b   = bus.req_b[XLEN-1:0];
            o_alu_select = bus.req_sel[3:0];
            w_mux_tag    = bus.req_tag[TAG_W-1:0];
        end
    end

    assign w_sel_ok = ({1'b0, o_alu_select} < LP_NUM_OPS);

    // Capture the ALU result into the granted requester's buffer, or drain a consumed entry
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_resp_valid  <= 2'b00;
            r_resp_result <= '0;
            r_resp_tag    <= '0;
            r_resp_err    <= 2'b00;
            r_rr_last     <= 1'b1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_grant[i]) begin
                    r_resp_valid[i] <= 1'b1;
                    r_resp_tag[i]   <= w_mux_tag;
                    if (w_sel_ok) begin
                        r_resp_result[i] <= i_alu_result;
                        r_resp_err[i]    <= 1'b0;
                    end else begin
                        r_resp_result[i] <= '0;
                        r_resp_err[i]    <= 1'b1;
                    end
                end else if (r_resp_valid[i] && bus.resp_ready[i]) begin
                    r_resp_valid[i] <= 1'b0;
                end
            end
            if (w_any_grant) begin
                r_rr_last <= w_grant[1];
            end
        end
    end

    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_result = r_resp_result;
    assign bus.resp_tag    = r_resp_tag;
    assign bus.resp_err    = r_resp_err;

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_stat_busy;
    logic [CNT_W-1:0] r_stat_conflict;

    // Saturating activity counters: grant cycles and two-way contention cycles
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_busy     <= '0;
            r_stat_conflict <= '0;
        end else begin
            if (w_any_grant && (r_stat_busy != {CNT_W{1'b1}})) begin
                r_stat_busy <= r_stat_busy + 1'b1;
            end
            if ((w_elig == 2'b11) && (r_stat_conflict != {CNT_W{1'b1}})) begin
                r_stat_conflict <= r_stat_conflict + 1'b1;
            end
        end
    end

    assign o_stat_busy     = r_stat_busy;
    assign o_stat_conflict = r_stat_conflict;
`endif

endmodule
